// File: rtl/stage2_id.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with WB bypass,
// control decode, load-use/branch hazard stalls and branch/jump resolution in ID.
module stage2_id (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_p4,
  input  logic [31:0] im_out,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  output logic        pc_src,
  output logic [31:0] pc_addr,
  output logic        if_stall,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [7:0]  ex_ctl
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'd0,
    OP_J     = 6'd2,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_ADDI  = 6'd8,
    OP_LW    = 6'd35,
    OP_SW    = 6'd43
  } opcode_e;

  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_p4;
  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] rs_data, rt_data;
  logic [7:0]  ctl;
  logic [4:0]  ex_dest;
  logic        ex_writes_rs, ex_writes_rt;
  logic        mem_load_hit;
  logic        is_branch;
  logic        load_use;
  logic        branch_stall;
  logic        taken;
  logic [31:0] target;

  assign op       = ifid_instr[31:26];
  assign rs       = ifid_instr[25:21];
  assign rt       = ifid_instr[20:16];
  assign rd       = ifid_instr[15:11];
  assign imm_sext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  // Register read with same-cycle WB bypass; $0 is hardwired to zero.
  always_comb begin
    rs_data = regs[rs];
    rt_data = regs[rt];
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs)) rs_data = wb_data;
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rt)) rt_data = wb_data;
    if (rs == 5'd0) rs_data = '0;
    if (rt == 5'd0) rt_data = '0;
  end

  // ctl bits: [0] regwrite [1] memread [2] memwrite [3] memtoreg [4] alusrc [5] regdst [7:6] aluop
  always_comb begin
    ctl = '0;
    case (op)
      OP_RTYPE: if (ifid_instr != '0) ctl = 8'b10_1_0_0_0_0_1;
      OP_LW:    ctl = 8'b00_0_1_1_0_1_1;
      OP_SW:    ctl = 8'b00_0_1_0_1_0_0;
      OP_ADDI:  ctl = 8'b00_0_1_0_0_0_1;
      default:  ctl = '0;
    endcase
  end

  always_comb begin
    ex_dest      = ex_ctl[5] ? ex_rd : ex_rt;
    ex_writes_rs = ex_ctl[0] && (ex_dest == rs) && (rs != 5'd0);
    ex_writes_rt = ex_ctl[0] && (ex_dest == rt) && (rt != 5'd0);
    mem_load_hit = mem_memread && (mem_rd != 5'd0) && ((mem_rd == rs) || (mem_rd == rt));
    is_branch    = (op == OP_BEQ) || (op == OP_BNE);
    load_use     = ex_ctl[1] && (ex_dest != 5'd0) && ((ex_dest == rs) || (ex_dest == rt));
    branch_stall = is_branch && (ex_writes_rs || ex_writes_rt || mem_load_hit);
    if_stall     = load_use || branch_stall;
  end

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (op)
      OP_BEQ: begin
        taken  = (rs_data == rt_data);
        target = ifid_pc_p4 + {imm_sext[29:0], 2'b00};
      end
      OP_BNE: begin
        taken  = (rs_data != rt_data);
        target = ifid_pc_p4 + {imm_sext[29:0], 2'b00};
      end
      OP_J: begin
        taken  = 1'b1;
        target = {ifid_pc_p4[31:28], ifid_instr[25:0], 2'b00};
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
    pc_src  = taken && !if_stall;
    pc_addr = pc_src ? target : '0;
  end

  // Redirect flushes the fetched word; a stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr <= '0;
      ifid_pc_p4 <= '0;
    end else if (pc_src) begin
      ifid_instr <= '0;
      ifid_pc_p4 <= '0;
    end else if (!if_stall) begin
      ifid_instr <= im_out;
      ifid_pc_p4 <= pc_p4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_regwrite && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_ctl     <= '0;
    end else if (if_stall) begin
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_ctl     <= '0;
    end else begin
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= imm_sext;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_rd      <= rd;
      ex_ctl     <= ctl;
    end
  end

endmodule

// File: tb/tb_stage2_id.sv
// Directed bench for stage2_id: bypass, $0, load-use, branch/jump redirect,
// branch hazard stall and reset abandoning a stall.
module tb_stage2_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_p4;
  logic [31:0] im_out;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_memread;
  logic [4:0]  mem_rd;
  logic        pc_src;
  logic [31:0] pc_addr;
  logic        if_stall;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_ctl;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ADD_3_5_0 = 32'h00A0_1820;
  localparam logic [31:0] ADD_3_0_5 = 32'h0005_1820;
  localparam logic [31:0] LW_2_0_1  = 32'h8C22_0000;
  localparam logic [31:0] ADD_4_2_2 = 32'h0042_2020;
  localparam logic [31:0] BEQ_1_1_3 = 32'h1021_0003;
  localparam logic [31:0] J_40      = 32'h0800_0040;
  localparam logic [31:0] BNE_1_1_3 = 32'h1421_0003;
  localparam logic [31:0] BEQ_0_0_M = 32'h1000_FFFF;
  localparam logic [31:0] ADDI_7    = 32'h2007_1234;
  localparam logic [31:0] BEQ_7_5_1 = 32'h10E5_0001;

  stage2_id dut (
    .clk(clk), .rst_n(rst_n), .pc_p4(pc_p4), .im_out(im_out),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_memread(mem_memread), .mem_rd(mem_rd),
    .pc_src(pc_src), .pc_addr(pc_addr), .if_stall(if_stall),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctl(ex_ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_regwrite = we;
    wb_rd       = r;
    wb_data     = d;
  endtask

  initial begin
    rst_n = 1'b0; pc_p4 = '0; im_out = '0;
    wb(1'b0, 5'd0, 32'd0);
    mem_memread = 1'b0; mem_rd = '0;
    #2;
    check("rst_ex_ctl", {24'd0, ex_ctl}, 32'h0);
    check("rst_ex_rs_data", ex_rs_data, 32'h0);
    check("rst_if_stall", {31'd0, if_stall}, 32'h0);
    check("rst_pc_src", {31'd0, pc_src}, 32'h0);
    check("rst_pc_addr", pc_addr, 32'h0);
    #10 rst_n = 1'b1;

    // WB bypass into an R-type read
    im_out = ADD_3_5_0; pc_p4 = 32'h4; tick();
    wb(1'b1, 5'd5, 32'h1234); im_out = '0; tick();
    wb(1'b0, 5'd0, 32'd0);
    check("byp_rs_data", ex_rs_data, 32'h1234);
    check("byp_ex_ctl", {24'd0, ex_ctl}, 32'hA1);
    check("byp_ex_rd", {27'd0, ex_rd}, 32'd3);
    check("byp_ex_rs", {27'd0, ex_rs}, 32'd5);

    // $0 write ignored and never bypassed
    wb(1'b1, 5'd0, 32'hFFFF_FFFF); im_out = ADD_3_0_5; tick();
    im_out = '0; tick();
    check("r0_rs_data", ex_rs_data, 32'h0);
    check("r5_rt_data", ex_rt_data, 32'h1234);
    wb(1'b0, 5'd0, 32'd0);

    // Load-use: one bubble, add held then issued
    im_out = LW_2_0_1; tick();
    im_out = ADD_4_2_2; tick();
    check("lw_ex_ctl", {24'd0, ex_ctl}, 32'h1B);
    check("lu_stall", {31'd0, if_stall}, 32'h1);
    check("lu_pc_src", {31'd0, pc_src}, 32'h0);
    im_out = '0; tick();
    check("lu_bubble_ctl", {24'd0, ex_ctl}, 32'h0);
    check("lu_bubble_rs", {27'd0, ex_rs}, 32'd0);
    check("lu_stall_clr", {31'd0, if_stall}, 32'h0);

    // beq taken, fetched word behind it squashed
    im_out = BEQ_1_1_3; pc_p4 = 32'h10; tick();
    check("add_issue_ctl", {24'd0, ex_ctl}, 32'hA1);
    check("add_issue_rd", {27'd0, ex_rd}, 32'd4);
    check("beq_pc_src", {31'd0, pc_src}, 32'h1);
    check("beq_pc_addr", pc_addr, 32'h1C);
    im_out = ADD_4_2_2; pc_p4 = 32'h14; tick();
    check("beq_ex_ctl", {24'd0, ex_ctl}, 32'h0);
    check("beq_ex_imm", ex_imm, 32'h3);
    check("flush_pc_src", {31'd0, pc_src}, 32'h0);

    // jump target
    im_out = J_40; pc_p4 = 32'h8000_0008; tick();
    check("squash_ex_ctl", {24'd0, ex_ctl}, 32'h0);
    check("j_pc_src", {31'd0, pc_src}, 32'h1);
    check("j_pc_addr", pc_addr, 32'h8000_0100);
    im_out = BNE_1_1_3; pc_p4 = 32'h20; tick();

    // bne with equal operands; then MEM-load hazard on a branch
    im_out = BNE_1_1_3; pc_p4 = 32'h20; tick();
    check("bne_pc_src", {31'd0, pc_src}, 32'h0);
    check("bne_pc_addr", pc_addr, 32'h0);
    mem_memread = 1'b1; mem_rd = 5'd1; #1;
    check("memld_stall", {31'd0, if_stall}, 32'h1);
    mem_memread = 1'b0; mem_rd = '0;

    // negative branch offset
    im_out = BEQ_0_0_M; pc_p4 = 32'h40; tick();
    check("bneg_pc_addr", pc_addr, 32'h3C);
    im_out = '0; tick();
    check("bneg_ex_imm", ex_imm, 32'hFFFF_FFFF);

    // branch on a register written by EX: stall, then resolve via WB bypass
    im_out = ADDI_7; tick();
    im_out = BEQ_7_5_1; pc_p4 = 32'h50; tick();
    check("addi_ex_ctl", {24'd0, ex_ctl}, 32'h11);
    check("addi_ex_imm", ex_imm, 32'h1234);
    check("bh_stall", {31'd0, if_stall}, 32'h1);
    check("bh_pc_src", {31'd0, pc_src}, 32'h0);
    check("bh_pc_addr", pc_addr, 32'h0);
    im_out = '0; tick();
    check("bh_bubble_ctl", {24'd0, ex_ctl}, 32'h0);
    wb(1'b1, 5'd7, 32'h1234); #1;
    check("bh_stall_clr", {31'd0, if_stall}, 32'h0);
    check("bh_pc_src_res", {31'd0, pc_src}, 32'h1);
    check("bh_pc_addr_res", pc_addr, 32'h54);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // reset asserted mid-stall
    im_out = LW_2_0_1; tick();
    im_out = ADD_4_2_2; tick();
    check("rs_pre_stall", {31'd0, if_stall}, 32'h1);
    #1 rst_n = 1'b0; #1;
    check("rs_if_stall", {31'd0, if_stall}, 32'h0);
    check("rs_ex_ctl", {24'd0, ex_ctl}, 32'h0);
    check("rs_ex_rt", {27'd0, ex_rt}, 32'd0);
    check("rs_pc_src", {31'd0, pc_src}, 32'h0);
    #1 rst_n = 1'b1;
    im_out = ADD_3_5_0; pc_p4 = 32'h4; tick();
    im_out = '0; tick();
    check("rs_rf_cleared", ex_rs_data, 32'h0);
    check("rs_add_ctl", {24'd0, ex_ctl}, 32'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
